// File: rtl/spi_dac_sequencer.sv
// spi_dac_sequencer
//   Front-end for a 16-bit MSB-first spi_master driving a multi-channel DAC.
//   Channel writes land in per-channel shadow registers and set a pending bit.
//   When idle, all pending channels are snapshotted into one frame. One command
//   word per channel is issued in ascending channel order, followed by a single
//   ldac_n low pulse so every channel in the frame updates together.
//
//   Optional feature: define SPI_WDT_EN to add a watchdog on the spi_busy
//   handshake. A stalled word sets a sticky err and abandons the frame
//   without an LDAC pulse. Without the macro, err is tied low.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   ch_wr      in   per-channel write strobe (one cycle per write)
//   ch_data    in   packed 12-bit data, channel i at [12*i+11:12*i]
//   spi_busy   in   busy from spi_master
//   spi_start  out  one-cycle start pulse to spi_master
//   spi_word   out  command word {ch[1:0], CTRL_BITS, data[11:0]}
//   ldac_n     out  active-low DAC latch strobe
//   busy       out  high whenever the FSM is not idle
//   frame_done out  one-cycle pulse as ldac_n returns high
//   err        out  sticky watchdog error
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: spi_start is a single-cycle request and spi_word is held from
// that cycle until spi_busy has been seen high and then low again; spi_busy
// already high in the start cycle counts as the rising edge.
module spi_dac_sequencer #(
   parameter int         NUM_CH      = 4,
   parameter logic [1:0] CTRL_BITS   = 2'b11,
   parameter int         LDAC_CYC    = 2,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      ch_wr,
   input  logic [NUM_CH*12-1:0]   ch_data,
   input  logic                   spi_busy,
   output logic                   spi_start,
   output logic [15:0]            spi_word,
   output logic                   ldac_n,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   err,
   output logic [2:0]             dbg_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT_HI = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_NEXT    = 3'd4;
   localparam logic [2:0] S_LDAC    = 3'd5;

   localparam int LW = (LDAC_CYC > 1) ? $clog2(LDAC_CYC) : 1;

   if (NUM_CH < 1 || NUM_CH > 4 || LDAC_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("spi_dac_sequencer: illegal parameter value");
   end

   logic [2:0]        state_q, state_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] frame_mask_q, frame_mask_d;
   logic [11:0]       shadow_q [NUM_CH];
   logic [11:0]       shadow_d [NUM_CH];
   logic [11:0]       frame_buf_q [NUM_CH];
   logic [11:0]       frame_buf_d [NUM_CH];
   logic [LW-1:0]     cnt_q, cnt_d;
   logic              ldac_n_q, ldac_n_d;
   logic              frame_done_q, frame_done_d;
   logic              spi_start_q, spi_start_d;
   logic [15:0]       spi_word_q, spi_word_d;
   logic [NUM_CH-1:0] snap_clr;
   logic [1:0]        k_cur, k_next;

`ifdef SPI_WDT_EN
   localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [WW-1:0] wdt_q, wdt_d;
   logic          err_q, err_d;
`endif

   // Index of the lowest set bit; ascending channel order within a frame.
   function automatic logic [1:0] pick_lowest(input logic [NUM_CH-1:0] m);
      logic [1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      frame_mask_d = frame_mask_q;
      frame_buf_d  = frame_buf_q;
      shadow_d     = shadow_q;
      ldac_n_d     = ldac_n_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      spi_start_d  = 1'b0;
      spi_word_d   = spi_word_q;
      snap_clr     = '0;
      k_cur        = pick_lowest(frame_mask_q);
`ifdef SPI_WDT_EN
      wdt_d        = wdt_q;
      err_d        = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            // Snapshot uses the old shadows: a write in this same cycle
            // belongs to the next frame.
            if (pending_q != '0) begin
               frame_mask_d = pending_q;
               frame_buf_d  = shadow_q;
               snap_clr     = pending_q;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_HI;
`ifdef SPI_WDT_EN
            wdt_d   = '0;
`endif
         end
         S_WAIT_HI: begin
            if (spi_busy) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!spi_busy) begin
               frame_mask_d[k_cur] = 1'b0;
               state_d             = S_NEXT;
            end
         end
         S_NEXT: begin
            if (frame_mask_q != '0) begin
               state_d = S_ISSUE;
            end else begin
               ldac_n_d = 1'b0;
               cnt_d    = LW'(LDAC_CYC - 1);
               state_d  = S_LDAC;
            end
         end
         S_LDAC: begin
            if (cnt_q == '0) begin
               ldac_n_d     = 1'b1;
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef SPI_WDT_EN
      // A stalled handshake abandons the rest of the frame, skipping LDAC.
      if (state_q == S_WAIT_HI || state_q == S_WAIT_LO) begin
         if (wdt_q == WW'(TIMEOUT_CYC - 1)) begin
            err_d        = 1'b1;
            frame_mask_d = '0;
            state_d      = S_IDLE;
         end else begin
            wdt_d = wdt_q + WW'(1);
         end
      end
`endif

      // Writes are accepted in every state.
      pending_d = (pending_q & ~snap_clr) | ch_wr;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_wr[i]) shadow_d[i] = ch_data[12*i +: 12];
      end

      // Word and start are registered on entry to ISSUE so both are valid
      // during the ISSUE cycle and the word stays put until the next issue.
      k_next = pick_lowest(frame_mask_d);
      if (state_d == S_ISSUE && state_q != S_ISSUE) begin
         spi_start_d = 1'b1;
         spi_word_d  = {k_next, CTRL_BITS, frame_buf_d[k_next]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         frame_mask_q <= '0;
         shadow_q     <= '{default: '0};
         frame_buf_q  <= '{default: '0};
         cnt_q        <= '0;
         ldac_n_q     <= 1'b1;
         frame_done_q <= 1'b0;
         spi_start_q  <= 1'b0;
         spi_word_q   <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         frame_mask_q <= frame_mask_d;
         shadow_q     <= shadow_d;
         frame_buf_q  <= frame_buf_d;
         cnt_q        <= cnt_d;
         ldac_n_q     <= ldac_n_d;
         frame_done_q <= frame_done_d;
         spi_start_q  <= spi_start_d;
         spi_word_q   <= spi_word_d;
      end
   end

`ifdef SPI_WDT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wdt_q <= wdt_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign spi_start  = spi_start_q;
   assign spi_word   = spi_word_q;
   assign ldac_n     = ldac_n_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != S_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_dac_sequencer.sv
// Testbench for spi_dac_sequencer: directed channel writes, an spi_master
// stand-in that answers each start with a busy pulse, and a per-cycle
// monitor checking the word stream, LDAC pulses and reset behaviour.
module tb_spi_dac_sequencer;

   localparam int NUM_CH   = 4;
   localparam int LDAC_CYC = 2;
`ifdef SPI_WDT_EN
   localparam int TIMEOUT_CYC = 16;
`else
   localparam int TIMEOUT_CYC = 1024;
`endif

   logic                 clk;
   logic                 reset;
   logic [NUM_CH-1:0]    ch_wr;
   logic [NUM_CH*12-1:0] ch_data;
   logic                 spi_busy;
   logic                 spi_start;
   logic [15:0]          spi_word;
   logic                 ldac_n;
   logic                 busy;
   logic                 frame_done;
   logic                 err;
   logic [2:0]           dbg_state;

   spi_dac_sequencer #(
      .NUM_CH      (NUM_CH),
      .CTRL_BITS   (2'b11),
      .LDAC_CYC    (LDAC_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ch_wr      (ch_wr),
      .ch_data    (ch_data),
      .spi_busy   (spi_busy),
      .spi_start  (spi_start),
      .spi_word   (spi_word),
      .ldac_n     (ldac_n),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 2ms");
      $fatal(1, "global timeout");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_starts = 0;
   int          n_ldac   = 0;
   int          n_fdone  = 0;
   logic [16:0] exp_q[$];        // {last_word_of_frame, command word}
   logic [15:0] last_word = '0;
   logic [15:0] held_word = '0;
   bit          outstanding = 0;
   bit          seen_hi     = 0;
   bit          need_ldac   = 0;
   bit          cur_last    = 0;
   bit          prev_ldac   = 1;
   int          low_w       = 0;
   bit          resp_en     = 1;
   bit          busy_hold   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Command word from the channel number and data: ch at bits 15:14,
   // control field 3 at bits 13:12, data below.
   function automatic logic [15:0] cmd(input int ch, input logic [11:0] d);
      return 16'(ch * 16384 + 3 * 4096 + int'(d));
   endfunction

   function automatic logic [47:0] lane(input int ch, input logic [11:0] d);
      logic [47:0] v;
      v = '0;
      v[ch*12 +: 12] = d;
      return v;
   endfunction

   // ---------------- spi_master stand-in ----------------
   initial begin
      spi_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (busy_hold) begin
            spi_busy = 1'b1;
         end else if (spi_start && resp_en) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #2;
            end
            spi_busy = 1'b1;
            repeat ($urandom_range(4, 12)) begin
               @(posedge clk);
               #2;
            end
            spi_busy = 1'b0;
         end else begin
            spi_busy = 1'b0;
         end
      end
   end

   // ---------------- per-cycle monitor ----------------
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            outstanding = 0;
            seen_hi     = 0;
            need_ldac   = 0;
            low_w       = 0;
            prev_ldac   = 1;
            check("rst_ldac_n", 32'(ldac_n), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_spi_start", 32'(spi_start), 32'd0);
            check("rst_frame_done", 32'(frame_done), 32'd0);
            continue;
         end
`ifndef SPI_WDT_EN
         check("err_tied_low", 32'(err), 32'd0);
`endif
         if (spi_start) begin
            n_starts++;
            check("frame_interleave", 32'(need_ldac), 32'd0);
            check("start_busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
               check("start_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("spi_word", 32'(spi_word), 32'(e[15:0]));
               cur_last = e[16];
            end
            last_word   = spi_word;
            held_word   = spi_word;
            outstanding = 1;
            seen_hi     = spi_busy;
         end else if (outstanding) begin
            check("word_stable", 32'(spi_word), 32'(held_word));
            if (spi_busy) seen_hi = 1;
            else if (seen_hi) begin
               outstanding = 0;
               if (cur_last) need_ldac = 1;
            end
         end
         if (!ldac_n) begin
            check("ldac_vs_spi_busy", 32'(spi_busy), 32'd0);
            check("ldac_vs_outstanding", 32'(outstanding), 32'd0);
            check("ldac_expected", 32'(need_ldac), 32'd1);
            check("ldac_busy", 32'(busy), 32'd1);
            low_w++;
         end else if (!prev_ldac) begin
            check("ldac_width", 32'(low_w), 32'(LDAC_CYC));
            check("frame_done_at_ldac_end", 32'(frame_done), 32'd1);
            n_ldac++;
            need_ldac = 0;
            low_w     = 0;
         end else begin
            check("frame_done_spurious", 32'(frame_done), 32'd0);
         end
         if (frame_done) n_fdone++;
         prev_ldac = ldac_n;
      end
   end

   // ---------------- driver tasks ----------------
   int wr_cyc = 0;

   task automatic write_chs(input logic [3:0] m, input logic [47:0] d);
      @(posedge clk);
      #1;
      ch_wr   = m;
      ch_data = d;
      wr_cyc  = cyc;
      @(posedge clk);
      #1;
      ch_wr = '0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int  stable;
      stable = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !need_ldac && !outstanding && !busy && !spi_busy) stable++;
         else stable = 0;
         if (stable >= 3) break;
      end
      check(name, 32'(stable >= 3), 32'd1);
   endtask

   task automatic wait_spi_busy(input string name, input int max_cyc);
      bit seen;
      seen = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (spi_busy) begin
            seen = 1;
            break;
         end
      end
      check(name, 32'(seen), 32'd1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int l0, f0, s0, lat;
      bit got;
      reset   = 1'b1;
      ch_wr   = '0;
      ch_data = '0;
      repeat (3) @(negedge clk);
      check("reset_spi_word", 32'(spi_word), 32'h0);
      check("reset_err", 32'(err), 32'd0);
      #2;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ldac_n", 32'(ldac_n), 32'd1);

      // Single write to ch2: start two cycles later with the literal word.
      l0 = n_ldac; f0 = n_fdone;
      exp_q.push_back({1'b1, cmd(2, 12'hABC)});
      write_chs(4'b0100, lane(2, 12'hABC));
      got = 0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (spi_start) begin
            got = 1;
            lat = cyc - wr_cyc;
            check("t1_word_literal", 32'(spi_word), 32'h0000BABC);
            break;
         end
      end
      check("t1_start_seen", 32'(got), 32'd1);
      check("t1_latency", 32'(lat), 32'd2);
      wait_idle("t1_idle", 200);
      check("t1_ldac_pulses", 32'(n_ldac - l0), 32'd1);
      check("t1_frame_done", 32'(n_fdone - f0), 32'd1);

      // ch3 and ch0 in one cycle: ascending order, one LDAC after both.
      l0 = n_ldac; f0 = n_fdone;
      exp_q.push_back({1'b0, cmd(0, 12'h123)});
      exp_q.push_back({1'b1, cmd(3, 12'hFFF)});
      write_chs(4'b1001, lane(3, 12'hFFF) | lane(0, 12'h123));
      wait_idle("t2_idle", 300);
      check("t2_last_word_literal", 32'(last_word), 32'h0000FFFF);
      check("t2_ldac_pulses", 32'(n_ldac - l0), 32'd1);
      check("t2_frame_done", 32'(n_fdone - f0), 32'd1);

      // ch1 written while the ch0 frame is mid-word: goes to a second frame.
      l0 = n_ldac; f0 = n_fdone;
      exp_q.push_back({1'b1, cmd(0, 12'h5A5)});
      exp_q.push_back({1'b1, cmd(1, 12'h800)});
      write_chs(4'b0001, lane(0, 12'h5A5));
      wait_spi_busy("t3_busy_rise", 40);
      write_chs(4'b0010, lane(1, 12'h800));
      wait_idle("t3_idle", 300);
      check("t3_last_word_literal", 32'(last_word), 32'h00007800);
      check("t3_ldac_pulses", 32'(n_ldac - l0), 32'd2);
      check("t3_frame_done", 32'(n_fdone - f0), 32'd2);

      // Two back-to-back writes to ch1 while busy: only the last value goes out.
      l0 = n_ldac; f0 = n_fdone;
      exp_q.push_back({1'b1, cmd(0, 12'h001)});
      exp_q.push_back({1'b1, cmd(1, 12'h222)});
      write_chs(4'b0001, lane(0, 12'h001));
      wait_spi_busy("t4_busy_rise", 40);
      @(posedge clk); #1; ch_wr = 4'b0010; ch_data = lane(1, 12'h111);
      @(posedge clk); #1; ch_wr = 4'b0010; ch_data = lane(1, 12'h222);
      @(posedge clk); #1; ch_wr = '0;
      wait_idle("t4_idle", 300);
      check("t4_last_word_literal", 32'(last_word), 32'h00007222);
      check("t4_ldac_pulses", 32'(n_ldac - l0), 32'd2);

      // Reset in the middle of the first word of a two-word frame.
      exp_q.push_back({1'b0, cmd(0, 12'h456)});
      exp_q.push_back({1'b1, cmd(1, 12'h789)});
      write_chs(4'b0011, lane(0, 12'h456) | lane(1, 12'h789));
      wait_spi_busy("t5_busy_rise", 40);
      @(negedge clk);
      check("t5_busy_before_reset", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_async_ldac_n", 32'(ldac_n), 32'd1);
      check("t5_async_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      s0 = n_starts; f0 = n_fdone; l0 = n_ldac;
      repeat (60) @(negedge clk);
      check("t5_no_restart", 32'(n_starts - s0), 32'd0);
      check("t5_no_frame_done", 32'(n_fdone - f0), 32'd0);
      check("t5_no_ldac", 32'(n_ldac - l0), 32'd0);
      check("t5_idle_busy", 32'(busy), 32'd0);

`ifdef SPI_WDT_EN
      // spi_busy stuck high: watchdog fires, frame dropped without LDAC.
      l0 = n_ldac; f0 = n_fdone;
      busy_hold = 1;
      exp_q.push_back({1'b0, cmd(0, 12'h0AA)});
      write_chs(4'b0001, lane(0, 12'h0AA));
      got = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (err) begin
            got = 1;
            break;
         end
      end
      check("t6_err_set", 32'(got), 32'd1);
      @(negedge clk);
      check("t6_idle_after_timeout", 32'(busy), 32'd0);
      check("t6_err_sticky", 32'(err), 32'd1);
      busy_hold = 0;
      repeat (10) @(negedge clk);
      check("t6_no_ldac", 32'(n_ldac - l0), 32'd0);
      check("t6_no_frame_done", 32'(n_fdone - f0), 32'd0);
      check("t6_err_still_set", 32'(err), 32'd1);
      #2;
      reset = 1'b1;
      @(negedge clk);
      check("t6_err_cleared", 32'(err), 32'd0);
      #2;
      reset = 1'b0;
      repeat (3) @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
